asr_ctrl_seq: RTL and testbench
===============================

ASR_CTRL_SEQ -- requirements
Module: asr_ctrl_seq

Interface
REQ-001 Parameter WIDTH, default 8, number of controlled bits (downstream negative-edge set/reset flop bank).
REQ-002 Parameter PULSE_CYC, default 2, low-pulse length of RSTB_O/SETB_O in CLK cycles (legal 1..15).
REQ-003 Parameter SETTLE_CYC, default 1, quiet cycles after release before next request (legal 1..15).
REQ-004 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 REQ_VALID  input  1  request present.
REQ-007 REQ_READY  output  1  block accepts a request this cycle.
REQ-008 REQ_OP  input  2  00 NOP, 01 CLEAR, 10 PRESET, 11 LOAD.
REQ-009 REQ_DATA  input  WIDTH  bit mask for CLEAR/PRESET; data word for LOAD.
REQ-010 RSTB_O  output  WIDTH  active-low async reset to downstream flops.
REQ-011 SETB_O  output  WIDTH  active-low async set to downstream flops.
REQ-012 D_O  output  WIDTH  data to downstream flops (captured on their negedge CLK).
REQ-013 BUSY  output  1  high in every state except IDLE.
REQ-014 DONE  output  1  one-cycle pulse on completion of an accepted request.

Function
REQ-015 All outputs SHALL be registered and change only on posedge CLK, giving half-cycle setup/hold margin to the downstream negedge capture.
REQ-016 States SHALL be INIT, IDLE, PULSE, SETTLE, LOAD.
REQ-017 REQ_READY SHALL be 1 only in IDLE; a request is accepted when REQ_VALID and REQ_READY are both 1 at posedge.
REQ-018 NOP, or CLEAR/PRESET with REQ_DATA == 0, SHALL leave outputs unchanged, stay in IDLE, and pulse DONE the next cycle.
REQ-019 CLEAR SHALL drive RSTB_O = ~mask, SETB_O all ones, go to PULSE with counter = PULSE_CYC.
REQ-020 PRESET SHALL drive SETB_O = ~mask, RSTB_O all ones, go to PULSE with counter = PULSE_CYC.
REQ-021 PULSE SHALL decrement the counter each cycle; at counter == 1 it SHALL drive RSTB_O and SETB_O all ones and go to SETTLE with counter = SETTLE_CYC.
REQ-022 SETTLE SHALL decrement; at counter == 1 go to IDLE, DONE = 1 for that first IDLE cycle.
REQ-023 Accept-to-REQ_READY latency for CLEAR/PRESET SHALL be exactly PULSE_CYC + SETTLE_CYC cycles; active-low pulse width exactly PULSE_CYC cycles.
REQ-024 LOAD SHALL register D_O = REQ_DATA at accept, remain in LOAD one cycle, then IDLE with DONE; D_O SHALL hold its last value afterwards.
REQ-025 Invariant: no bit SHALL ever have RSTB_O and SETB_O both 0 in the same cycle.
REQ-026 REQ_OP/REQ_DATA outside the accept cycle SHALL be ignored; REQ_VALID held high while busy SHALL be accepted at the first IDLE cycle.

Reset
REQ-027 While RST = 1: RSTB_O all zeros, SETB_O all ones, D_O zero, REQ_READY 0, BUSY 1, DONE 0, state INIT, counter = PULSE_CYC.
REQ-028 After RST falls, INIT SHALL hold RSTB_O low PULSE_CYC more cycles, then release and pass through SETTLE to IDLE without a DONE pulse.
REQ-029 RST asserted mid-operation SHALL abort immediately to REQ-027 values; the aborted request never produces DONE.

Structure
REQ-030 Shared package asr_ctrl_pkg SHALL hold the op encoding enum, the state enum, and counter width constant (4 bits).
REQ-031 One sub-module asr_ctrl_cnt (loadable down-counter with ==1 flag) SHALL be used for PULSE and SETTLE timing.

Verification
REQ-032 Reset release, defaults: RSTB_O=0x00 for 2 cycles after RST falls, then 0xFF, REQ_READY=1 at cycle 3, DONE never pulses.
REQ-033 CLEAR mask 0x0F: RSTB_O=0xF0 for exactly 2 cycles, SETB_O=0xFF throughout, DONE at cycle 3, REQ_READY back at cycle 3.
REQ-034 PRESET mask 0xA5 back-to-back after LOAD 0x3C with REQ_VALID held: D_O=0x3C, DONE, then SETB_O=0x5A for 2 cycles; invariant REQ-025 checked every cycle.
REQ-035 CLEAR mask 0x00 and NOP: outputs unchanged, BUSY stays 0, DONE one cycle after accept.
REQ-036 RST pulsed during PULSE of CLEAR 0xFF: outputs jump to reset values asynchronously, no DONE, REQ-028 sequence then repeats.
REQ-037 Parameters PULSE_CYC=1, SETTLE_CYC=3: CLEAR low pulse 1 cycle, REQ_READY returns after 4 cycles.

Source files
------------

// File: rtl/asr_ctrl_pkg.sv
// asr_ctrl_pkg
// Shared types and constants for the async set/reset sequencer:
//   CNT_W   - width of the PULSE/SETTLE timing counter
//   op_e    - request opcode encoding
//   state_e - sequencer state encoding
package asr_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_PRESET = 2'b10,
        OP_LOAD   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        PULSE,
        SETTLE,
        LOAD
    } state_e;

endpackage

// File: rtl/asr_ctrl_cnt.sv
// asr_ctrl_cnt
// Loadable down-counter used for the PULSE and SETTLE timing of the sequencer.
// Ports:
//   CLK, RST    - clock, asynchronous active-high reset (counter -> RST_VAL)
//   i_load      - load i_load_val (takes priority over decrement)
//   i_load_val  - value to load
//   i_dec       - decrement by one (saturates at zero)
//   o_cnt       - current count
//   o_one       - count equals one (terminal count)
module asr_ctrl_cnt
    import asr_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = 4'd1
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_one
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_one = (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/asr_ctrl_seq.sv
// asr_ctrl_seq
// Sequencer driving a downstream bank of negedge-capturing flops that have
// active-low async set and reset. Every output is registered on posedge CLK so
// the downstream negedge capture sees half a cycle of setup and hold.
// Ports:
//   CLK, RST         - clock, asynchronous active-high reset
//   REQ_VALID/READY  - request handshake (READY only in IDLE)
//   REQ_OP           - 00 NOP, 01 CLEAR, 10 PRESET, 11 LOAD
//   REQ_DATA         - bit mask (CLEAR/PRESET) or data word (LOAD)
//   RSTB_O, SETB_O   - active-low async reset / set to the flop bank
//   D_O              - data to the flop bank
//   BUSY             - high in every state except IDLE
//   DONE             - one-cycle pulse when an accepted request completes
//
// state  | meaning
// -------+-----------------------------------------------------------------
// INIT   | power-on reset pulse on RSTB_O, counter runs PULSE_CYC
// IDLE   | ready for a request
// PULSE  | CLEAR/PRESET low pulse active, counter runs PULSE_CYC
// SETTLE | pulse released, quiet time of SETTLE_CYC before next request
// LOAD   | one cycle hold after registering D_O
module asr_ctrl_seq
    import asr_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 1
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [1:0]       REQ_OP,
    input  logic [WIDTH-1:0] REQ_DATA,
    output logic [WIDTH-1:0] RSTB_O,
    output logic [WIDTH-1:0] SETB_O,
    output logic [WIDTH-1:0] D_O,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYC);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

    state_e           r_state;
    logic [WIDTH-1:0] r_rstb;
    logic [WIDTH-1:0] r_setb;
    logic [WIDTH-1:0] r_d;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    // Set while coming out of reset so the INIT->SETTLE->IDLE pass gives no DONE.
    logic             r_boot;

    state_e           w_state_nxt;
    logic [WIDTH-1:0] w_rstb_nxt;
    logic [WIDTH-1:0] w_setb_nxt;
    logic [WIDTH-1:0] w_d_nxt;
    logic             w_done_nxt;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_cnt_dec;
    logic             w_cnt_one;
    logic [CNT_W-1:0] w_cnt;
    logic             w_accept;
    op_e              w_op;

    asr_ctrl_cnt #(
        .RST_VAL (PULSE_LD)
    ) u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_cnt      (w_cnt),
        .o_one      (w_cnt_one)
    );

    // r_ready mirrors (r_state == IDLE), so it doubles as the accept qualifier.
    assign w_accept = REQ_VALID && r_ready;
    assign w_op     = op_e'(REQ_OP);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= INIT;
            r_rstb  <= '0;
            r_setb  <= '1;
            r_d     <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_boot  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_rstb  <= w_rstb_nxt;
            r_setb  <= w_setb_nxt;
            r_d     <= w_d_nxt;
            r_ready <= (w_state_nxt == IDLE);
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_done_nxt;
            r_boot  <= r_boot && (w_state_nxt != IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rstb_nxt  = r_rstb;
        w_setb_nxt  = r_setb;
        w_d_nxt     = r_d;
        w_done_nxt  = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_val   = PULSE_LD;
        w_cnt_dec   = 1'b0;

        case (r_state)
            INIT, PULSE: begin
                if (w_cnt_one) begin
                    w_rstb_nxt  = '1;
                    w_setb_nxt  = '1;
                    w_state_nxt = SETTLE;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = SETTLE_LD;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_CLEAR: begin
                            if (REQ_DATA != '0) begin
                                // Set side stays released so no bit sees both low.
                                w_rstb_nxt  = ~REQ_DATA;
                                w_setb_nxt  = '1;
                                w_state_nxt = PULSE;
                                w_cnt_load  = 1'b1;
                            end else begin
                                w_done_nxt = 1'b1;
                            end
                        end
                        OP_PRESET: begin
                            if (REQ_DATA != '0) begin
                                w_setb_nxt  = ~REQ_DATA;
                                w_rstb_nxt  = '1;
                                w_state_nxt = PULSE;
                                w_cnt_load  = 1'b1;
                            end else begin
                                w_done_nxt = 1'b1;
                            end
                        end
                        OP_LOAD: begin
                            w_d_nxt     = REQ_DATA;
                            w_state_nxt = LOAD;
                        end
                        default: begin
                            w_done_nxt = 1'b1;
                        end
                    endcase
                end
            end
            SETTLE: begin
                if (w_cnt_one) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = ~r_boot;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            LOAD: begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_rstb_nxt  = '1;
                w_setb_nxt  = '1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign REQ_READY = r_ready;
    assign RSTB_O    = r_rstb;
    assign SETB_O    = r_setb;
    assign D_O       = r_d;
    assign BUSY      = r_busy;
    assign DONE      = r_done;

endmodule

// File: tb/tb_asr_ctrl_seq.sv
// tb_asr_ctrl_seq
// Self-checking bench for asr_ctrl_seq: default-parameter instance driven from a
// vector table plus hand sequences, and a PULSE_CYC=1/SETTLE_CYC=3 instance.
module tb_asr_ctrl_seq;
    import asr_ctrl_pkg::*;

    localparam int W = 8;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic         valid, ready, busy, done;
    logic [1:0]   op;
    logic [W-1:0] data, rstb, setb, dout;

    logic         valid2, ready2, busy2, done2;
    logic [1:0]   op2;
    logic [W-1:0] data2, rstb2, setb2, dout2;

    asr_ctrl_seq #(.WIDTH(W), .PULSE_CYC(2), .SETTLE_CYC(1)) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(valid), .REQ_READY(ready),
        .REQ_OP(op), .REQ_DATA(data), .RSTB_O(rstb), .SETB_O(setb),
        .D_O(dout), .BUSY(busy), .DONE(done)
    );

    asr_ctrl_seq #(.WIDTH(W), .PULSE_CYC(1), .SETTLE_CYC(3)) dut2 (
        .CLK(CLK), .RST(RST), .REQ_VALID(valid2), .REQ_READY(ready2),
        .REQ_OP(op2), .REQ_DATA(data2), .RSTB_O(rstb2), .SETB_O(setb2),
        .D_O(dout2), .BUSY(busy2), .DONE(done2)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] rstb;
        logic [W-1:0] setb;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_e;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] data;
        logic [W-1:0] p_rstb;
        logic [W-1:0] p_setb;
        logic [W-1:0] d;
        logic         busy;
        int           lat;
        int           low;
    } vec_t;

    localparam int NV = 9;
    vec_t vec[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] d);
        exp_t e;
        e.d    = d;
        e.rstb = '1;
        e.setb = '1;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (ready !== 1'b1 && k < 30) begin
            step();
            k++;
        end
        chk("wait_ready", 32'(ready), 1);
    endtask

    // Entered with RST high, at posedge+1.
    task automatic reset_release_check(input string tag);
        chk({tag, "_rst_rstb"},  32'(rstb),  32'h00);
        chk({tag, "_rst_setb"},  32'(setb),  32'hFF);
        chk({tag, "_rst_d"},     32'(dout),  32'h00);
        chk({tag, "_rst_ready"}, 32'(ready), 0);
        chk({tag, "_rst_busy"},  32'(busy),  1);
        chk({tag, "_rst_done"},  32'(done),  0);
        chk({tag, "_rst_d2"},    32'(dout2), 32'h00);
        chk({tag, "_rst_busy2"}, 32'(busy2), 1);
        RST = 1'b0;
        step();
        chk({tag, "_c1_rstb"},   32'(rstb),   32'h00);
        chk({tag, "_c1_ready"},  32'(ready),  0);
        chk({tag, "_c1_rstb2"},  32'(rstb2),  32'hFF);
        step();
        chk({tag, "_c2_rstb"},   32'(rstb),   32'hFF);
        chk({tag, "_c2_ready"},  32'(ready),  0);
        chk({tag, "_c2_busy"},   32'(busy),   1);
        step();
        chk({tag, "_c3_ready"},  32'(ready),  1);
        chk({tag, "_c3_busy"},   32'(busy),   0);
        chk({tag, "_c3_ready2"}, 32'(ready2), 0);
        step();
        chk({tag, "_c4_ready2"}, 32'(ready2), 1);
    endtask

    // Scoreboard: every DONE must match the oldest outstanding request.
    always @(posedge CLK) begin
        #1;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_unexpected: got DONE=1, want no DONE (t=%0t)", $time);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_d",    32'(dout), 32'(sb_e.d));
                chk("sb_rstb", 32'(rstb), 32'(sb_e.rstb));
                chk("sb_setb", 32'(setb), 32'(sb_e.setb));
            end
        end
    end

    always @(negedge CLK) begin
        n_cmp++;
        if (((~rstb & ~setb) != '0) || ((~rstb2 & ~setb2) != '0)) begin
            n_err++;
            $display("FAIL invariant: rstb=0x%0h setb=0x%0h rstb2=0x%0h setb2=0x%0h, want no bit both low",
                     rstb, setb, rstb2, setb2);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t, want finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int low;

        //            op     data   p_rstb p_setb d      busy lat low
        vec[0] = '{2'b01, 8'h0F, 8'hF0, 8'hFF, 8'h00, 1'b1, 3, 2};
        vec[1] = '{2'b00, 8'h55, 8'hFF, 8'hFF, 8'h00, 1'b0, 0, 0};
        vec[2] = '{2'b01, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0, 0, 0};
        vec[3] = '{2'b10, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0, 0, 0};
        vec[4] = '{2'b11, 8'h3C, 8'hFF, 8'hFF, 8'h3C, 1'b1, 1, 0};
        vec[5] = '{2'b10, 8'h81, 8'hFF, 8'h7E, 8'h3C, 1'b1, 3, 2};
        vec[6] = '{2'b01, 8'hFF, 8'h00, 8'hFF, 8'h3C, 1'b1, 3, 2};
        vec[7] = '{2'b11, 8'hC3, 8'hFF, 8'hFF, 8'hC3, 1'b1, 1, 0};
        vec[8] = '{2'b00, 8'h00, 8'hFF, 8'hFF, 8'hC3, 1'b0, 0, 0};

        RST = 1'b1;
        valid = 1'b0; op = 2'b00; data = '0;
        valid2 = 1'b0; op2 = 2'b00; data2 = '0;
        step();
        step();
        reset_release_check("por");

        for (int i = 0; i < NV; i++) begin
            wait_ready();
            op = vec[i].op; data = vec[i].data; valid = 1'b1;
            push_exp(vec[i].d);
            step();
            valid = 1'b0;
            op = 2'($urandom);
            data = W'($urandom);
            chk($sformatf("v%0d_rstb", i), 32'(rstb), 32'(vec[i].p_rstb));
            chk($sformatf("v%0d_setb", i), 32'(setb), 32'(vec[i].p_setb));
            chk($sformatf("v%0d_d", i),    32'(dout), 32'(vec[i].d));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vec[i].busy));
            lat = 0;
            low = (rstb != 8'hFF || setb != 8'hFF) ? 1 : 0;
            while (ready !== 1'b1 && lat < 20) begin
                step();
                lat++;
                if (rstb != 8'hFF || setb != 8'hFF) low++;
            end
            chk($sformatf("v%0d_lat", i),  lat, vec[i].lat);
            chk($sformatf("v%0d_low", i),  low, vec[i].low);
            chk($sformatf("v%0d_done", i), 32'(done), 1);
        end

        // LOAD then PRESET with REQ_VALID held across the busy cycle.
        wait_ready();
        op = 2'b11; data = 8'h3C; valid = 1'b1;
        push_exp(8'h3C);
        step();
        chk("b2b_load_d",     32'(dout),  32'h3C);
        chk("b2b_load_ready", 32'(ready), 0);
        op = 2'b10; data = 8'hA5;
        push_exp(8'h3C);
        step();
        chk("b2b_load_done",  32'(done),  1);
        chk("b2b_idle_ready", 32'(ready), 1);
        step();
        valid = 1'b0;
        chk("b2b_pre_setb",   32'(setb), 32'h5A);
        chk("b2b_pre_rstb",   32'(rstb), 32'hFF);
        chk("b2b_pre_done",   32'(done), 0);
        step();
        chk("b2b_pre_setb2",  32'(setb), 32'h5A);
        step();
        chk("b2b_rel_setb",   32'(setb), 32'hFF);
        chk("b2b_rel_ready",  32'(ready), 0);
        step();
        chk("b2b_end_ready",  32'(ready), 1);
        chk("b2b_end_done",   32'(done),  1);

        // Reset in the middle of a CLEAR pulse.
        wait_ready();
        op = 2'b01; data = 8'hFF; valid = 1'b1;
        push_exp(8'h3C);
        step();
        valid = 1'b0;
        chk("abort_pulse_rstb", 32'(rstb), 32'h00);
        #2;
        RST = 1'b1;
        exp_q.delete();
        #1;
        chk("abort_async_d",     32'(dout),  32'h00);
        chk("abort_async_setb",  32'(setb),  32'hFF);
        chk("abort_async_ready", 32'(ready), 0);
        chk("abort_async_busy",  32'(busy),  1);
        chk("abort_async_done",  32'(done),  0);
        step();
        step();
        reset_release_check("abort");

        // PULSE_CYC=1, SETTLE_CYC=3 instance.
        op2 = 2'b01; data2 = 8'h3C; valid2 = 1'b1;
        step();
        valid2 = 1'b0;
        chk("p1_rstb", 32'(rstb2), 32'hC3);
        chk("p1_setb", 32'(setb2), 32'hFF);
        lat = 0;
        low = (rstb2 != 8'hFF) ? 1 : 0;
        while (ready2 !== 1'b1 && lat < 20) begin
            step();
            lat++;
            if (rstb2 != 8'hFF) low++;
            if (ready2 !== 1'b1) chk("p1_no_early_done", 32'(done2), 0);
        end
        chk("p1_lat",  lat, 4);
        chk("p1_low",  low, 1);
        chk("p1_done", 32'(done2), 1);

        step();
        chk("final_done",     32'(done), 0);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
